// File: rtl/lsu_dmem_if_if.sv
// Core-side request/response bundle for the load/store unit.
// master: execute stage issuing requests; slave: the LSU serving them.
interface lsu_dmem_if_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              done;
  logic [31:0]       rdata;
  logic              misalign;
  logic              fault;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, done, rdata, misalign, fault
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, done, rdata, misalign, fault
  );

endinterface

// File: rtl/lsu_dmem_if.sv
// Load/store unit between execute and a word-addressed data memory.
// Loads and word stores take one memory cycle; byte/half stores do a read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses are
// flagged and skipped; when undefined, low address bits are truncated to the access size.
module lsu_dmem_if #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_dmem_if_if.slave req_if,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  state_e      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        done_q;
  logic        misalign_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [1:0]  req_size;
  logic        req_funct_bad;
  logic        req_range_bad;
  logic        req_misalign;
  logic        req_is_word;

  logic [1:0]  byte_off;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  // Fault decode of the incoming request, evaluated in the accept cycle.
  always_comb begin
    req_size    = req_if.req_funct3[1:0];
    req_is_word = (req_size == 2'b10);
    if (req_if.req_is_store) begin
      req_funct_bad = req_if.req_funct3[2] || (req_size == 2'b11);
    end else begin
      req_funct_bad = (req_size == 2'b11) || (req_if.req_funct3 == 3'b110);
    end
    req_range_bad = ADDR_W'(req_if.req_addr[ADDR_W-1:2]) >= ADDR_W'(MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    req_misalign = !req_funct_bad &&
                   (((req_size == 2'b01) && req_if.req_addr[0]) ||
                    ((req_size == 2'b10) && (req_if.req_addr[1:0] != 2'b00)));
`else
    req_misalign = 1'b0;
`endif
  end

  // Lane selection for loads and lane merge for sub-word stores.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   byte_off = addr_lo_q;
      2'b01:   byte_off = {addr_lo_q[1], 1'b0};  // addr[0] ignored for halves
      default: byte_off = 2'b00;
    endcase
    shamt    = {byte_off, 3'b000};
    rd_shift = mem_rdata_i >> shamt;
    case (funct3_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {24'h0, rd_shift[7:0]};
      3'b101:  load_val = {16'h0, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
    lane_mask = (funct3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << shamt;
    merged    = (mem_rdata_i & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  // Control FSM; every output is a register so strobes drop as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_if.req_valid && req_ready_q) begin
            is_store_q  <= req_if.req_is_store;
            funct3_q    <= req_if.req_funct3;
            addr_lo_q   <= req_if.req_addr[1:0];
            wdata_q     <= req_if.req_wdata;
            req_ready_q <= 1'b0;
            if (req_funct_bad || req_range_bad || req_misalign) begin
              state_q    <= StResp;
              done_q     <= 1'b1;
              fault_q    <= req_funct_bad || req_range_bad;
              misalign_q <= req_misalign;
            end else begin
              state_q    <= StAccess;
              mem_addr_q <= 32'({req_if.req_addr[ADDR_W-1:2], 2'b00});
              // Word stores write directly; everything else reads first.
              if (req_if.req_is_store && req_is_word) begin
                mem_write_q <= 1'b1;
                mem_wdata_q <= req_if.req_wdata;
              end else begin
                mem_read_q <= 1'b1;
              end
            end
          end
        end
        StAccess: begin
          if (!is_store_q) begin
            rdata_q <= load_val;
            state_q <= StResp;
            done_q  <= 1'b1;
          end else if (funct3_q[1:0] == 2'b10) begin
            state_q <= StResp;
            done_q  <= 1'b1;
          end else begin
            mem_write_q <= 1'b1;
            mem_wdata_q <= merged;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          state_q <= StResp;
          done_q  <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_if.req_ready = req_ready_q;
  assign req_if.done      = done_q;
  assign req_if.rdata     = rdata_q;
  assign req_if.misalign  = misalign_q;
  assign req_if.fault     = fault_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Bench for lsu_dmem_if: directed table, randomized run against a byte-level model,
// mid-operation reset, and back-to-back store/load.
`timescale 1ns/1ps
module tb_lsu_dmem_if;

  localparam int unsigned MemWords = 256;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    logic        mis;
    logic        flt;
    int          rd;
    int          wr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int          rd;
    int          wr;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        both;
    logic        stray;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_dmem_if_if #(.ADDR_W(32)) bus ();

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_dmem_if #(.MEM_WORDS(MemWords), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_if     (bus),
    .mem_read_o (mem_read),
    .mem_write_o(mem_write),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Data memory: combinational read, synchronous write, plus a bench preload port.
  logic [31:0] dmem [MemWords];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_data = 32'h0;

  always_comb mem_rdata = (mem_read && (mem_addr[31:10] == 22'h0)) ? dmem[mem_addr[9:2]] : 32'h0;

  always_ff @(posedge clk) begin
    if (pre_we) dmem[pre_idx] <= pre_data;
    else if (mem_write && (mem_addr[31:10] == 22'h0)) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  // Reference state.
  logic [31:0] ref_mem [MemWords];
  logic [31:0] ref_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 8'(idx); pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Behavioural model: works on the memory word as an array of little-endian bytes.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    logic        legal;
    logic        range_bad;
    logic        mis;
    int          size;
    int          off;
    int unsigned idx;
    logic [7:0]  b [4];
    logic [31:0] w;
    logic [31:0] val;
    size  = int'(f3) % 4;
    idx   = a / 4;
    legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 ||
                                 f3 == 3'd5);
    range_bad = idx >= MemWords;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = legal && ((size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0));
`else
    mis = 1'b0;
`endif
    e.mis = mis;
    e.flt = !legal || range_bad;
    e.wdata = 32'h0;
    e.rd = 0;
    e.wr = 0;
    e.lat = 1;
    if (!e.flt && !e.mis) begin
      w = ref_mem[idx];
      for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
      off = int'(a % 4);
      if (size == 1) off = off - (off % 2);
      if (size == 2) off = 0;
      if (!st) begin
        if (size == 0) begin
          val = {24'h0, b[off]};
          if (f3 == 3'd0 && b[off] >= 8'd128) val = val | 32'hffffff00;
        end else if (size == 1) begin
          val = {16'h0, b[off+1], b[off]};
          if (f3 == 3'd1 && val >= 32'd32768) val = val | 32'hffff0000;
        end else begin
          val = w;
        end
        ref_rdata = val;
        e.lat = 2;
        e.rd  = 1;
      end else if (size == 2) begin
        ref_mem[idx] = wd;
        e.lat = 2;
        e.wr = 1;
        e.wdata = wd;
      end else begin
        b[off] = wd[7:0];
        if (size == 1) b[off+1] = wd[15:8];
        w = {b[3], b[2], b[1], b[0]};
        ref_mem[idx] = w;
        e.lat = 3;
        e.rd = 1;
        e.wr = 1;
        e.wdata = w;
      end
    end
    e.rdata = ref_rdata;
  endtask

  // Issue one request, wait for acceptance and completion, record observed behaviour.
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, output res_t r);
    int n;
    r = '{default: 0};
    bus.req_valid = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    n = 0;
    @(negedge clk);
    chk({tag, " done pulse width"}, 32'(bus.done), 32'h0);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL %s accept: req_ready stayed 0, want 1", tag);
      bus.req_valid = 1'b0;
      r.lat = -1;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (mem_read) begin
        r.rd++; r.rd_cyc = c; r.raddr = mem_addr;
      end
      if (mem_write) begin
        r.wr++; r.wr_cyc = c; r.waddr = mem_addr; r.wdata = mem_wdata;
      end
      if (mem_read && mem_write) r.both = 1'b1;
      if (bus.done) begin
        r.lat = c; r.rdata = bus.rdata; r.mis = bus.misalign; r.flt = bus.fault;
        break;
      end
      if (bus.misalign || bus.fault) r.stray = 1'b1;
    end
    if (r.lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s done: no done within 10 cycles, want done", tag);
    end
  endtask

  task automatic check_req(input string tag, input exp_t e, input res_t r,
                           input logic [31:0] a);
    chk({tag, " latency"}, 32'(r.lat), 32'(e.lat));
    chk({tag, " rdata"}, r.rdata, e.rdata);
    chk({tag, " misalign"}, 32'(r.mis), 32'(e.mis));
    chk({tag, " fault"}, 32'(r.flt), 32'(e.flt));
    chk({tag, " read strobes"}, 32'(r.rd), 32'(e.rd));
    chk({tag, " write strobes"}, 32'(r.wr), 32'(e.wr));
    chk({tag, " rd+wr overlap"}, 32'(r.both), 32'h0);
    chk({tag, " stray flags"}, 32'(r.stray), 32'h0);
    if (e.rd > 0) begin
      chk({tag, " read addr"}, r.raddr, a & 32'hffff_fffc);
      chk({tag, " read cycle"}, 32'(r.rd_cyc), 32'd1);
    end
    if (e.wr > 0) begin
      chk({tag, " write addr"}, r.waddr, a & 32'hffff_fffc);
      chk({tag, " write data"}, r.wdata, e.wdata);
      chk({tag, " write cycle"}, 32'(r.wr_cyc), 32'(e.lat - 1));
    end
    if (a[31:10] == 22'h0) chk({tag, " mem word"}, dmem[a[9:2]], ref_mem[a[9:2]]);
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int lat,
                              input logic mis, input logic flt, input int nrd, input int nwr,
                              input logic [31:0] wdata);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wd = wd;
    v.e.rdata = rd; v.e.lat = lat; v.e.mis = mis; v.e.flt = flt;
    v.e.rd = nrd; v.e.wr = nwr; v.e.wdata = wdata;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [11];
    res_t        r;
    exp_t        e;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  ld_ok [5];

    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'h0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    ref_rdata = 32'h0;
    ld_ok[0] = 3'd0; ld_ok[1] = 3'd1; ld_ok[2] = 3'd2; ld_ok[3] = 3'd4; ld_ok[4] = 3'd5;

    for (int i = 0; i < int'(MemWords); i++) preload(i, $urandom);
    preload(1, 32'h0);
    preload(4, 32'h8899aabb);

    // Reset values while held in reset.
    chk("reset req_ready", 32'(bus.req_ready), 32'h1);
    chk("reset done", 32'(bus.done), 32'h0);
    chk("reset rdata", bus.rdata, 32'h0);
    chk("reset misalign", 32'(bus.misalign), 32'h0);
    chk("reset fault", 32'(bus.fault), 32'h0);
    chk("reset mem_read", 32'(mem_read), 32'h0);
    chk("reset mem_write", 32'(mem_write), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = mk(1'b0, 3'd0, 32'h13, 32'h0, 32'hffffff88, 2, 1'b0, 1'b0, 1, 0, 32'h0);
    vecs[1] = mk(1'b0, 3'd5, 32'h10, 32'h0, 32'h0000aabb, 2, 1'b0, 1'b0, 1, 0, 32'h0);
    vecs[2] = mk(1'b0, 3'd1, 32'h12, 32'h0, 32'hffff8899, 2, 1'b0, 1'b0, 1, 0, 32'h0);
    vecs[3] = mk(1'b1, 3'd0, 32'h11, 32'h123456cc, 32'hffff8899, 3, 1'b0, 1'b0, 1, 1,
                 32'h8899ccbb);
    vecs[4] = mk(1'b0, 3'd2, 32'h10, 32'h0, 32'h8899ccbb, 2, 1'b0, 1'b0, 1, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[5] = mk(1'b1, 3'd2, 32'h06, 32'hdeadbeef, 32'h8899ccbb, 1, 1'b1, 1'b0, 0, 0, 32'h0);
`else
    vecs[5] = mk(1'b1, 3'd2, 32'h06, 32'hdeadbeef, 32'h8899ccbb, 2, 1'b0, 1'b0, 0, 1,
                 32'hdeadbeef);
`endif
    vecs[6] = mk(1'b0, 3'd2, 32'h400, 32'h0, 32'h8899ccbb, 1, 1'b0, 1'b1, 0, 0, 32'h0);
    vecs[7] = mk(1'b1, 3'd4, 32'h20, 32'h55, 32'h8899ccbb, 1, 1'b0, 1'b1, 0, 0, 32'h0);
    vecs[8] = mk(1'b0, 3'd4, 32'h13, 32'h0, 32'h00000088, 2, 1'b0, 1'b0, 1, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[9]  = mk(1'b0, 3'd2, 32'h04, 32'h0, 32'h00000000, 2, 1'b0, 1'b0, 1, 0, 32'h0);
    vecs[10] = mk(1'b0, 3'd1, 32'h11, 32'h0, 32'h00000000, 1, 1'b1, 1'b0, 0, 0, 32'h0);
`else
    vecs[9]  = mk(1'b0, 3'd2, 32'h04, 32'h0, 32'hdeadbeef, 2, 1'b0, 1'b0, 1, 0, 32'h0);
    vecs[10] = mk(1'b0, 3'd1, 32'h11, 32'h0, 32'hffffccbb, 2, 1'b0, 1'b0, 1, 0, 32'h0);
`endif

    for (int i = 0; i < 11; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, r);
      model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, e);  // keeps reference in step
      check_req($sformatf("vec%0d", i), vecs[i].e, r, vecs[i].addr);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      st = 1'($urandom % 2);
      if ($urandom % 4 == 0) f3 = 3'($urandom % 8);
      else if (st) f3 = 3'($urandom % 3);
      else f3 = ld_ok[$urandom % 5];
      a  = ($urandom % 16 == 0) ? $urandom : ($urandom % 1024);
      wd = $urandom;
      run_req($sformatf("rnd%0d", i), st, f3, a, wd, r);
      model(st, f3, a, wd, e);
      check_req($sformatf("rnd%0d", i), e, r, a);
    end

    // Reset while a half-word store sits in its write cycle.
    preload(8, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = 3'd1;
    bus.req_addr = 32'h22; bus.req_wdata = 32'h0000beef;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst-mid access read", 32'(mem_read), 32'h1);
    @(negedge clk);
    chk("rst-mid write strobe", 32'(mem_write), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst-mid write drop", 32'(mem_write), 32'h0);
    chk("rst-mid read drop", 32'(mem_read), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = 32'h0;
    @(negedge clk);
    chk("rst-mid mem word", dmem[8], 32'h11223344);
    chk("rst-mid req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst-mid rdata", bus.rdata, 32'h0);
    chk("rst-mid done", 32'(bus.done), 32'h0);

    // Back-to-back SW then LW to the same word.
    wd = $urandom;
    run_req("b2b sw", 1'b1, 3'd2, 32'h40, wd, r);
    model(1'b1, 3'd2, 32'h40, wd, e);
    check_req("b2b sw", e, r, 32'h40);
    run_req("b2b lw", 1'b0, 3'd2, 32'h40, 32'h0, r);
    model(1'b0, 3'd2, 32'h40, 32'h0, e);
    check_req("b2b lw", e, r, 32'h40);
    chk("b2b lw data", r.rdata, wd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_if.md
Name: lsu_dmem_if

Overview:
- Load/store unit between the core's execute stage and the word-addressed data memory.
- Memory side: combinational read (read strobe, address, read data) and synchronous write (write strobe, address, write data), one 32-bit word per address.
- Handles LB/LH/LW/LBU/LHU and SB/SH/SW, including byte-lane extraction and sign/zero extension.
- Sub-word stores use a two-cycle read-modify-write. Misaligned and out-of-range accesses are flagged.
- Valid/ready request handshake; one-cycle done pulse.

Parameters:
- MEM_WORDS, 256: depth of data memory in words; word index = addr[31:2]; index >= MEM_WORDS is a range fault.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  1  core request present; held by core until accepted
- req_ready  out  1  LSU idle, can accept
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result; valid when done is high after a load
- misalign  out  1  valid with done: alignment fault
- fault  out  1  valid with done: illegal funct3 or range fault
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  word-aligned byte address: {addr[31:2], 2'b00}
- mem_wdata  out  32  write word
- mem_rdata  in  32  memory read word, combinational from mem_addr/mem_read

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP.
- Reset values: state=IDLE; req_ready=1; done=0; rdata=0; misalign=0; fault=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
- Reset is asynchronous and active low. Asserting rst_n mid-operation aborts the operation, with no write issued after the assertion edge. All memory strobes come from registered state, so they fall immediately when reset asserts.
- IDLE: req_ready=1. On req_valid & req_ready, latch is_store, funct3, addr and wdata, then evaluate faults:
  - Illegal funct3: load 011/110/111; store anything other than 000/001/010.
  - Range fault: addr[31:2] >= MEM_WORDS.
  - Misalignment: half with addr[0]=1; word with addr[1:0]!=0.
  - Any fault -> RESP with flags set; no memory strobe is ever driven.
  - Otherwise -> ACCESS.
- ACCESS: req_ready=0; mem_addr is driven.
  - Load: mem_read=1. Capture mem_rdata, select lane by addr[1:0] (byte) or addr[1] (half), sign-extend for 000/001, zero-extend for 100/101; store in rdata. -> RESP.
  - SW: mem_write=1, mem_wdata=wdata. -> RESP.
  - SB/SH: mem_read=1. Capture mem_rdata and merge wdata[7:0] or wdata[15:0] into the addressed lane. -> WRITE.
- WRITE: mem_write=1, mem_wdata=merged word, same mem_addr. -> RESP.
- RESP: done=1 for exactly one cycle with misalign/fault valid. -> IDLE. misalign and fault are 0 in every other cycle.
- Latency, accept edge to done cycle: load 2, SW 2, SB/SH 3, faulted 1.
- Back-to-back: next request is accepted in the cycle after RESP.
- rdata holds its value until the next successful load completes. It is not updated on stores or faults.
- mem_read and mem_write are never high in the same cycle.
- req_valid while busy is ignored. The core must hold the request until req_ready.
- Little-endian: byte 0 = bits [7:0].

Optional Feature:
- LSU_MISALIGN_TRAP_EN
- Defined: misaligned accesses are flagged as above and perform no memory access.
- Undefined: no misalignment check. The low address bits are truncated to the access size (half: addr[0] ignored; word: addr[1:0] ignored), the access proceeds normally, and misalign is tied to 0.
- Range and funct3 faults are unaffected in both cases.

Test Plan:
- Memory word 4 = 32'h8899AABB; LB addr 0x13 -> done at accept+2, rdata=32'hFFFFFF88; mem_read high one cycle, mem_addr=0x10.
- Same word; LHU addr 0x10 -> rdata=32'h0000AABB; LH addr 0x12 -> rdata=32'hFFFF8899.
- SB addr 0x11, wdata=32'h123456CC on word 0x8899AABB -> mem_read at accept+1, mem_write at accept+2 with mem_wdata=32'h8899CCBB, done at accept+3.
- With LSU_MISALIGN_TRAP_EN: SW addr 0x06 -> done at accept+1, misalign=1, no mem_write. Without it: word 1 written, misalign=0.
- Load addr 0x400 (MEM_WORDS=256) -> fault=1, no strobes. Store with funct3=100 -> fault=1, no strobes.
- SH in flight, rst_n low during WRITE state -> mem_write falls immediately, memory word unchanged, req_ready=1 after release. Then SW then LW issued back-to-back -> LW returns the SW data.
